// File: rtl/stopwatch_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_counter_if
// Description : Control pulses in, BCD digits and run flag out.
// Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_counter_if;
    logic       tick_1hz;
    logic       tick_adj;
    logic       pause;
    logic       adj;
    logic       sel;
    logic [4:0] min_l;
    logic [4:0] min_r;
    logic [4:0] sec_l;
    logic [4:0] sec_r;
    logic       running;

    modport master (
        output tick_1hz, tick_adj, pause, adj, sel,
        input  min_l, min_r, sec_l, sec_r, running
    );

    modport slave (
        input  tick_1hz, tick_adj, pause, adj, sel,
        output min_l, min_r, sec_l, sec_r, running
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_counter
// Description : MM:SS BCD stopwatch core with run/pause and field adjust.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_counter #(
    parameter int MIN_LIMIT = 99
) (
    input  wire logic          clk,
    input  wire logic          rst,
    stopwatch_counter_if.slave bus
);

    localparam logic [3:0] c_LIM_TENS = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] c_LIM_ONES = 4'(MIN_LIMIT % 10);

    logic       running_q, running_d;
    logic [3:0] min_l_q, min_l_d;
    logic [3:0] min_r_q, min_r_d;
    logic [3:0] sec_l_q, sec_l_d;
    logic [3:0] sec_r_q, sec_r_d;

    logic [3:0] w_sec_r_inc, w_sec_l_inc, w_min_r_inc, w_min_l_inc;
    logic       w_sec_r_wrap, w_sec_l_wrap, w_min_r_wrap, w_min_at_limit;
    logic       w_sec_step, w_min_step;

    // Per-digit incrementers; ">=" also sends any non-BCD value back to 0.
    always_comb begin
        w_sec_r_wrap   = (sec_r_q >= 4'd9);
        w_sec_r_inc    = w_sec_r_wrap ? 4'd0 : sec_r_q + 4'd1;
        w_sec_l_wrap   = (sec_l_q >= 4'd5);
        w_sec_l_inc    = w_sec_l_wrap ? 4'd0 : sec_l_q + 4'd1;
        w_min_r_wrap   = (min_r_q >= 4'd9);
        w_min_r_inc    = w_min_r_wrap ? 4'd0 : min_r_q + 4'd1;
        w_min_l_inc    = (min_l_q >= 4'd9) ? 4'd0 : min_l_q + 4'd1;
        w_min_at_limit = (min_l_q == c_LIM_TENS) && (min_r_q == c_LIM_ONES);
    end

    always_comb begin
        w_sec_step = 1'b0;
        w_min_step = 1'b0;
        if (bus.adj) begin
            if (bus.tick_adj) begin
                w_sec_step = bus.sel;
                w_min_step = ~bus.sel;
            end
        end else if (running_q && bus.tick_1hz) begin
            w_sec_step = 1'b1;
            w_min_step = w_sec_r_wrap && w_sec_l_wrap;
        end

        sec_r_d = w_sec_step ? w_sec_r_inc : sec_r_q;
        sec_l_d = (w_sec_step && w_sec_r_wrap) ? w_sec_l_inc : sec_l_q;

        min_r_d = min_r_q;
        min_l_d = min_l_q;
        if (w_min_step) begin
            if (w_min_at_limit) begin
                min_r_d = 4'd0;
                min_l_d = 4'd0;
            end else begin
                min_r_d = w_min_r_inc;
                min_l_d = w_min_r_wrap ? w_min_l_inc : min_l_q;
            end
        end

        // Ticks above see the pre-toggle run flag.
        running_d = running_q ^ bus.pause;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running_q <= 1'b0;
            min_l_q   <= 4'd0;
            min_r_q   <= 4'd0;
            sec_l_q   <= 4'd0;
            sec_r_q   <= 4'd0;
        end else begin
            running_q <= running_d;
            min_l_q   <= min_l_d;
            min_r_q   <= min_r_d;
            sec_l_q   <= sec_l_d;
            sec_r_q   <= sec_r_d;
        end
    end

    assign bus.min_l   = {1'b0, min_l_q};
    assign bus.min_r   = {1'b0, min_r_q};
    assign bus.sec_l   = {1'b0, sec_l_q};
    assign bus.sec_r   = {1'b0, sec_r_q};
    assign bus.running = running_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_counter
// Description : Directed bench for stopwatch_counter at MIN_LIMIT 99 and 5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_counter;

    logic clk;
    logic rst;
    logic tick_1hz, tick_adj, pause, adj, sel;
    int   checks;
    int   failures;
    logic started;

    stopwatch_counter_if a_if ();
    stopwatch_counter_if b_if ();

    assign a_if.tick_1hz = tick_1hz;
    assign a_if.tick_adj = tick_adj;
    assign a_if.pause    = pause;
    assign a_if.adj      = adj;
    assign a_if.sel      = sel;
    assign b_if.tick_1hz = tick_1hz;
    assign b_if.tick_adj = tick_adj;
    assign b_if.pause    = pause;
    assign b_if.adj      = adj;
    assign b_if.sel      = sel;

    stopwatch_counter #(.MIN_LIMIT(99)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    stopwatch_counter #(.MIN_LIMIT(5))  u_dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    logic [20:0] w_a_out, w_b_out;
    assign w_a_out = {a_if.min_l, a_if.min_r, a_if.sec_l, a_if.sec_r, a_if.running};
    assign w_b_out = {b_if.min_l, b_if.min_r, b_if.sec_l, b_if.sec_r, b_if.running};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: {run, minutes[6:0], seconds[6:0]} as plain integers.
    logic [14:0] m_a, m_b;

    function automatic logic [14:0] model_next(input int lim, input logic [14:0] st,
                                               input logic r, t1, ta, p, a, s);
        int   mm, ss, t;
        logic run;
        run = st[14];
        mm  = int'(st[13:7]);
        ss  = int'(st[6:0]);
        if (r) return 15'd0;
        if (a) begin
            if (ta) begin
                if (s) ss = (ss + 1) % 60;
                else   mm = (mm >= lim) ? 0 : mm + 1;
            end
        end else if (run && t1) begin
            t = mm * 60 + ss + 1;
            if (t > lim * 60 + 59) t = 0;
            mm = t / 60;
            ss = t % 60;
        end
        run = run ^ p;
        return {run, 7'(mm), 7'(ss)};
    endfunction

    function automatic logic [20:0] expect_of(input int mm, input int ss, input logic run);
        return {5'(mm / 10), 5'(mm % 10), 5'(ss / 10), 5'(ss % 10), run};
    endfunction

    initial begin
        m_a     = 15'd0;
        m_b     = 15'd0;
        started = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) started = 1'b1;
            m_a = model_next(99, m_a, rst, tick_1hz, tick_adj, pause, adj, sel);
            m_b = model_next(5,  m_b, rst, tick_1hz, tick_adj, pause, adj, sel);
        end
    end

    initial begin
        logic [20:0] ea, eb;
        forever begin
            @(negedge clk);
            if (started) begin
                ea = expect_of(int'(m_a[13:7]), int'(m_a[6:0]), m_a[14]);
                eb = expect_of(int'(m_b[13:7]), int'(m_b[6:0]), m_b[14]);
                checks++;
                if (w_a_out !== ea) begin
                    failures++;
                    $display("FAIL model_a t=%0t got=%h want=%h", $time, w_a_out, ea);
                end
                checks++;
                if (w_b_out !== eb) begin
                    failures++;
                    $display("FAIL model_b t=%0t got=%h want=%h", $time, w_b_out, eb);
                end
            end
        end
    end

    task automatic chk(input string name, input bit use_b, input int mm, input int ss,
                       input logic run);
        logic [20:0] act, exp_v;
        act   = use_b ? w_b_out : w_a_out;
        exp_v = expect_of(mm, ss, run);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s got=%h want=%h (%02d:%02d run=%0b)", name, act, exp_v, mm, ss, run);
        end
    endtask

    // Called on a negedge; presents one cycle of pulses and returns on the next negedge.
    task automatic step(input logic t1, input logic ta, input logic p);
        tick_1hz = t1;
        tick_adj = ta;
        pause    = p;
        @(negedge clk);
        tick_1hz = 1'b0;
        tick_adj = 1'b0;
        pause    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic adj_ticks(input logic field_sel, input int n);
        adj = 1'b1;
        sel = field_sel;
        repeat (n) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        tick_1hz = 1'b0;
        tick_adj = 1'b0;
        pause    = 1'b0;
        adj      = 1'b0;
        sel      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_a", 1'b0, 0, 0, 1'b0);
        chk("reset_b", 1'b1, 0, 0, 1'b0);

        step(1'b0, 1'b0, 1'b1);
        chk("pause_start", 1'b0, 0, 0, 1'b1);
        ticks(60);
        chk("carry_60s", 1'b0, 1, 0, 1'b1);
        ticks(11 * 60 + 34);
        chk("count_1234", 1'b0, 12, 34, 1'b1);
        do_reset();
        chk("reset_mid", 1'b0, 0, 0, 1'b0);

        adj_ticks(1'b1, 50);
        adj = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        ticks(9);
        chk("sec_50_59", 1'b0, 0, 59, 1'b1);
        adj_ticks(1'b0, 9);
        adj = 1'b0;
        ticks(1);
        chk("min_09_10", 1'b0, 10, 0, 1'b1);

        adj_ticks(1'b0, 89);
        adj_ticks(1'b1, 59);
        chk("preload_9959", 1'b0, 99, 59, 1'b1);
        adj = 1'b0;
        ticks(1);
        chk("wrap_99", 1'b0, 0, 0, 1'b1);

        do_reset();
        adj_ticks(1'b0, 5);
        adj_ticks(1'b1, 59);
        adj = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        ticks(1);
        chk("wrap_lim5", 1'b1, 0, 0, 1'b1);
        chk("no_wrap_lim99", 1'b0, 6, 0, 1'b1);

        do_reset();
        step(1'b0, 1'b0, 1'b1);
        adj_ticks(1'b0, 3);
        adj_ticks(1'b1, 58);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        chk("adj_sec_wrap_a", 1'b0, 3, 1, 1'b1);
        chk("adj_sec_wrap_b", 1'b1, 3, 1, 1'b1);
        ticks(2);
        chk("adj_ignores_1hz", 1'b0, 3, 1, 1'b1);

        do_reset();
        step(1'b0, 1'b0, 1'b1);
        adj_ticks(1'b0, 98);
        adj_ticks(1'b1, 30);
        adj_ticks(1'b0, 2);
        chk("adj_min_wrap", 1'b0, 0, 30, 1'b1);
        adj = 1'b0;
        ticks(1);
        chk("resume_after_adj", 1'b0, 0, 31, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("tick_adj_ignored", 1'b0, 0, 31, 1'b1);

        do_reset();
        adj_ticks(1'b1, 10);
        adj = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("pause_tick_same", 1'b0, 0, 11, 1'b0);
        ticks(1);
        chk("paused_ignores", 1'b0, 0, 11, 1'b0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
